mem_boot_loader: RTL and testbench
==================================

# mem_boot_loader

Synthesizable boot programmer sitting between a byte-stream source and the CPU's instruction/data memories. It streams segments into `NUM_CH` memory channels in order and owns each memory port while loading, then hands the ports to the CPU. After a cool-off interval it releases CPU reset, and it supports re-load without a system reset.

## Interface
- `ADDR_W`, 12, memory address width per channel
- `DATA_W`, 8, stream and memory word width
- `NUM_CH`, 2, number of memory channels (channel 0 = instruction, 1 = data); legal ≥1
- `COOL_CYCLES`, 32, cycles between end of load and CPU reset release; legal ≥1
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin load (sampled in IDLE only)
- `reload`  in  1  re-enter load (sampled in RUN/ERROR only)
- `s_data`  in  DATA_W  stream word
- `s_valid`  in  1  stream word valid
- `s_last`  in  1  last word of current channel's segment
- `s_ready`  out  1  loader accepts word
- `cpu_m_addr`  in  NUM_CH*ADDR_W  CPU-side address per channel, channel k at [k*ADDR_W +: ADDR_W]
- `cpu_m_wdata`  in  NUM_CH*DATA_W  CPU-side write data
- `cpu_m_wr`, `cpu_m_rd`, `cpu_m_en`  in  NUM_CH each  CPU-side strobes
- `m_addr`  out  NUM_CH*ADDR_W  memory address
- `m_wdata`  out  NUM_CH*DATA_W  memory write data
- `m_wr`, `m_rd`, `m_en`  out  NUM_CH each  memory strobes
- `cpu_rst`  out  1  active-high CPU reset
- `done`  out  1  load complete, CPU running
- `err`  out  1  sticky load error

## Operation
- States: IDLE, LOAD, COOL, RUN, ERROR. Reset → IDLE.
- Reset values: `s_ready`=0, `cpu_rst`=1, `done`=0, `err`=0, `m_wr`/`m_rd`/`m_en`=0, `m_addr`/`m_wdata`=0. Channel index and all address counters are 0.
- IDLE: `start`=1 → LOAD at channel 0.
- LOAD: `s_ready`=1. Each accepted word (`s_valid & s_ready`) is written to the current channel at its address counter, then the counter increments by 1.
- In LOAD, the loader drives the memory ports of every channel. Non-active channels get `m_en`=0.
- An accepted word with `s_last`=1 ends the segment and resets the channel address counter. The channel index then increments; after channel NUM_CH-1 the state goes to COOL.
- Address overflow: a word accepted when the counter is already 2^ADDR_W-1 and not `s_last` is written, and the counter saturates. Any further non-last words are accepted but discarded, and `err` is set. Loading continues.
- COOL: `s_ready`=0. Memory ports are muxed to the CPU-side inputs (pass-through, combinational). A counter runs COOL_CYCLES cycles, then the state goes to RUN.
- RUN: `cpu_rst`=0, `done`=1, ports stay with the CPU.
- ERROR (macro only): `cpu_rst`=1, `done`=0, ports muxed to the CPU side, `s_ready`=0.
- `reload`=1 in RUN or ERROR → LOAD at channel 0 with all counters 0, `err` cleared, and `cpu_rst`=1 and `done`=0 from the next cycle.
- `start` outside IDLE and `reload` in IDLE/LOAD/COOL are ignored.

## Timing
- Accept-to-write latency is 1 cycle. A word accepted at edge N produces `m_en`=`m_wr`=1 with the registered addr/data during cycle N+1.
- Throughput is 1 word/cycle. `s_ready` depends only on state, never on `s_valid`.
- The final write of the last segment occurs in the first COOL cycle. The mux switches to the CPU side on the second COOL cycle.
- `cpu_rst` falls exactly COOL_CYCLES+1 cycles after the edge that accepted the final `s_last` word.
- Asserting `reset` mid-LOAD aborts immediately to reset values. Partial memory contents are not cleared.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - The `s_last` word of each segment is a checksum and is not written.
  - The expected value is the two's-complement negation, mod 2^DATA_W, of the sum of that segment's payload words, so payload + checksum ≡ 0.
  - On mismatch: `err`=1 and go to ERROR instead of advancing. The CPU is held in reset until `reload`.
- Undefined: the `s_last` word is ordinary payload and is written. The ERROR state is unreachable.

## Test plan
- Defaults, no macro: `start`, then ch0 words 0xA1,0xB2,0xC3 (last on 0xC3) and ch1 word 0x55 (last) → ch0 writes 0x000←A1, 0x001←B2, 0x002←C3; ch1 writes 0x000←55. `cpu_rst` falls 33 cycles after the ch1 acceptance, and `done`=1.
- Random `s_valid` gaps on a 16-word segment → exactly 16 writes, contiguous addresses 0..15, no duplicates or drops.
- ADDR_W=4, 18 words to ch0 with the last on word 18 → addresses 0..15 written, word 17 discarded, word 18 written at 15, `err`=1, CPU still released.
- In RUN, pulse `reload` → `cpu_rst`=1 and `done`=0 next cycle, a new load writes from address 0, and `err` is cleared.
- `BOOT_LOADER_CHECKSUM_EN`: payload 0x10,0x20 with checksum 0xD0 → passes, nothing written for 0xD0. Checksum 0xD1 → ERROR, `err`=1, `cpu_rst` stays 1.
- `reset` pulsed mid-LOAD after 3 words → all outputs return to reset values within the same cycle, and the state is IDLE.

Source files
------------

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: boot programmer that streams byte segments into NUM_CH
// memory channels in order, then hands the memory ports to the CPU, waits a
// cool-off interval and releases CPU reset. Supports reload from RUN/ERROR.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
//   When defined, the s_last word of every segment is a checksum (two's
//   complement negation of the payload sum) and is not written; a mismatch
//   parks the loader in ERROR with the CPU held in reset until reload.
module mem_boot_loader #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 2,
    parameter int COOL_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       reload,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   cpu_m_addr,
    input  logic [NUM_CH*DATA_W-1:0]   cpu_m_wdata,
    input  logic [NUM_CH-1:0]          cpu_m_wr,
    input  logic [NUM_CH-1:0]          cpu_m_rd,
    input  logic [NUM_CH-1:0]          cpu_m_en,
    output logic [NUM_CH*ADDR_W-1:0]   m_addr,
    output logic [NUM_CH*DATA_W-1:0]   m_wdata,
    output logic [NUM_CH-1:0]          m_wr,
    output logic [NUM_CH-1:0]          m_rd,
    output logic [NUM_CH-1:0]          m_en,
    output logic                       cpu_rst,
    output logic                       done,
    output logic                       err
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(COOL_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COOL,
        RUN,
        ERROR
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [ADDR_W-1:0]   addr_cnt;
    logic                addr_sat;
    logic [CNT_W-1:0]    cool_cnt;
    logic [DATA_W-1:0]   sum;
    logic                port_cpu;

    logic                wr_pend;
    logic [CH_W-1:0]     wr_ch;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic                accept;
    logic                do_write;
    logic [DATA_W-1:0]   chk_total;
    logic                chk_ok;

    // s_ready is a pure decode of the LOAD state, so accept never loops back
    assign accept    = s_valid && s_ready;
    assign chk_total = sum + s_data;
    assign chk_ok    = (chk_total == '0);

    // A saturated counter discards further payload; the closing word always
    // lands at the held address unless it is a checksum.
    assign do_write = accept && (s_last ? !CHECKSUM_EN : !addr_sat);

    // Control FSM: sequencing, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= '0;
            addr_cnt <= '0;
            addr_sat <= 1'b0;
            cool_cnt <= '0;
            sum      <= '0;
            port_cpu <= 1'b0;
            s_ready  <= 1'b0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        s_ready  <= 1'b1;
                        ch       <= '0;
                        addr_cnt <= '0;
                        addr_sat <= 1'b0;
                        sum      <= '0;
                        port_cpu <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (s_last) begin
                            if (CHECKSUM_EN && !chk_ok) begin
                                state    <= ERROR;
                                s_ready  <= 1'b0;
                                err      <= 1'b1;
                                port_cpu <= 1'b1;
                            end else begin
                                addr_cnt <= '0;
                                addr_sat <= 1'b0;
                                sum      <= '0;
                                if (ch == CH_W'(NUM_CH - 1)) begin
                                    state    <= COOL;
                                    s_ready  <= 1'b0;
                                    cool_cnt <= '0;
                                end else begin
                                    ch <= ch + 1'b1;
                                end
                            end
                        end else begin
                            sum <= sum + s_data;
                            if (addr_sat) begin
                                err <= 1'b1;
                            end else if (addr_cnt == '1) begin
                                addr_sat <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end
                    end
                end
                COOL: begin
                    // First COOL cycle still carries the final write; the
                    // CPU gets the ports from the second cycle on.
                    port_cpu <= 1'b1;
                    if (cool_cnt == CNT_W'(COOL_CYCLES)) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cool_cnt <= cool_cnt + 1'b1;
                    end
                end
                RUN, ERROR: begin
                    if (reload) begin
                        state    <= LOAD;
                        s_ready  <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        ch       <= '0;
                        addr_cnt <= '0;
                        addr_sat <= 1'b0;
                        sum      <= '0;
                        port_cpu <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write stage: one-cycle registered memory write for each accepted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend <= 1'b0;
            wr_ch   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_pend <= do_write;
            if (do_write) begin
                wr_ch   <= ch;
                wr_addr <= addr_cnt;
                wr_data <= s_data;
            end
        end
    end

    // Port mux: loader owns every channel until the CPU takes over
    for (genvar k = 0; k < NUM_CH; k++) begin : g_port
        logic hit;
        assign hit = wr_pend && (wr_ch == CH_W'(k));
        assign m_addr[k*ADDR_W +: ADDR_W]  = port_cpu ? cpu_m_addr[k*ADDR_W +: ADDR_W]
                                                      : wr_addr;
        assign m_wdata[k*DATA_W +: DATA_W] = port_cpu ? cpu_m_wdata[k*DATA_W +: DATA_W]
                                                      : wr_data;
        assign m_en[k] = port_cpu ? cpu_m_en[k] : hit;
        assign m_wr[k] = port_cpu ? cpu_m_wr[k] : hit;
        assign m_rd[k] = port_cpu ? cpu_m_rd[k] : 1'b0;
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Self-checking bench for mem_boot_loader (default parameters). Expected
// memory writes are queued as stimulus is issued; a negedge monitor pops and
// compares every loader write. Build with BOOT_LOADER_CHECKSUM_EN to run the
// checksum flow instead of the plain-payload flow.
module tb_mem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        reload = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [23:0] cpu_m_addr  = 24'h456123;
    logic [15:0] cpu_m_wdata = 16'h9977;
    logic [1:0]  cpu_m_wr = 2'b00;
    logic [1:0]  cpu_m_rd = 2'b11;
    logic [1:0]  cpu_m_en = 2'b11;
    logic [23:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_wr;
    logic [1:0]  m_rd;
    logic [1:0]  m_en;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  ch;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];

    mem_boot_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .reload      (reload),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .cpu_m_addr  (cpu_m_addr),
        .cpu_m_wdata (cpu_m_wdata),
        .cpu_m_wr    (cpu_m_wr),
        .cpu_m_rd    (cpu_m_rd),
        .cpu_m_en    (cpu_m_en),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wr        (m_wr),
        .m_rd        (m_rd),
        .m_en        (m_en),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int ch, input int addr, input int data);
        wr_t w;
        w.ch   = 4'(ch);
        w.addr = 12'(addr);
        w.data = 8'(data);
        exp_q.push_back(w);
    endtask

    // Monitor: every loader write must match the oldest expected write
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (m_en[k] && m_wr[k]) begin
                    wr_t got;
                    got.ch   = 4'(k);
                    got.addr = m_addr[k*12 +: 12];
                    got.data = m_wdata[k*8 +: 8];
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(got), 64'hFFFF_FFFF);
                    end else begin
                        check("mem_write", 64'(got), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Present one word, wait (bounded) until it is accepted; returns at the accepting edge
    task automatic send(input logic [7:0] d, input logic l, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed 0, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic stop_stream();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_m_en", 64'(m_en), 64'd0);
        check("rst_m_wr", 64'(m_wr), 64'd0);
        check("rst_m_rd", 64'(m_rd), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_m_wdata", 64'(m_wdata), 64'd0);
        reset = 1'b0;

        // Start is needed to leave IDLE
        repeat (2) @(negedge clk);
        check("idle_no_ready", 64'(s_ready), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_s_ready", 64'(s_ready), 64'd1);
        check("load_m_rd", 64'(m_rd), 64'd0);
        check("load_m_en_idle", 64'(m_en), 64'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Good checksums: 0x10+0x20+0xD0 = 0x100, 0x05+0xFB = 0x100
        push(0, 0, 8'h10);
        push(0, 1, 8'h20);
        send(8'h10, 1'b0, 0);
        send(8'h20, 1'b0, 0);
        send(8'hD0, 1'b1, 0);
        push(1, 0, 8'h05);
        send(8'h05, 1'b0, 0);
        send(8'hFB, 1'b1, 0);
        stop_stream();
        wait_done(100);
        check("cs_ok_err", 64'(err), 64'd0);
        check("cs_ok_cpu_rst", 64'(cpu_rst), 64'd0);

        // Bad checksum: 0xD1 must trap in ERROR
        pulse_reload();
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        push(0, 0, 8'h10);
        push(0, 1, 8'h20);
        send(8'h10, 1'b0, 0);
        send(8'h20, 1'b0, 0);
        send(8'hD1, 1'b1, 0);
        stop_stream();
        repeat (5) @(posedge clk);
        #1;
        check("cs_bad_err", 64'(err), 64'd1);
        check("cs_bad_cpu_rst", 64'(cpu_rst), 64'd1);
        check("cs_bad_done", 64'(done), 64'd0);
        check("cs_bad_s_ready", 64'(s_ready), 64'd0);
        check("cs_bad_cpu_ports", 64'(m_en), 64'd3);

        pulse_reload();
        check("err_reload_clr", 64'(err), 64'd0);
        check("err_reload_ready", 64'(s_ready), 64'd1);
`else
        // Basic two-channel load with hand-computed writes
        push(0, 12'h000, 8'hA1);
        push(0, 12'h001, 8'hB2);
        push(0, 12'h002, 8'hC3);
        push(1, 12'h000, 8'h55);
        send(8'hA1, 1'b0, 0);
        send(8'hB2, 1'b0, 0);
        send(8'hC3, 1'b1, 0);
        send(8'h55, 1'b1, 0);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        // First COOL cycle: final write still owned by the loader
        check("cool1_m_en", 64'(m_en), 64'd2);
        check("cool1_s_ready", 64'(s_ready), 64'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("cool2_cpu_m_en", 64'(m_en), 64'd3);
                check("cool2_cpu_addr", 64'(m_addr), 64'h456123);
                check("cool2_cpu_rst", 64'(cpu_rst), 64'd1);
            end
        end while (cpu_rst && n < 200);
        check("cpu_rst_latency", 64'(n), 64'd33);
        check("run_done", 64'(done), 64'd1);
        check("run_err", 64'(err), 64'd0);
        check("run_wdata", 64'(m_wdata), 64'h9977);
        check("run_m_rd", 64'(m_rd), 64'd3);

        // Reload from RUN, 16-word segment with random valid gaps
        pulse_reload();
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        check("reload_s_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            push(0, i, 8'h40 + i);
            send(8'(8'h40 + i), 1'(i == 15), int'($urandom_range(0, 3)));
        end
        push(1, 0, 8'h66);
        send(8'h66, 1'b1, 1);
        stop_stream();
        wait_done(100);
        check("gap_err", 64'(err), 64'd0);

        // Address overflow: 4098 words into ch0, last on word 4098
        pulse_reload();
        for (int i = 1; i <= 4098; i++) begin
            if (i <= 4096) push(0, i - 1, i & 8'hFF);
            else if (i == 4098) push(0, 4095, i & 8'hFF);
            send(8'(i), 1'(i == 4098), 0);
            if (i == 4096) begin
                #1;
                check("ovf_err_before", 64'(err), 64'd0);
            end
            if (i == 4097) begin
                #1;
                check("ovf_err_set", 64'(err), 64'd1);
            end
        end
        push(1, 0, 8'h77);
        send(8'h77, 1'b1, 0);
        stop_stream();
        wait_done(100);
        check("ovf_err_sticky", 64'(err), 64'd1);
        check("ovf_cpu_released", 64'(cpu_rst), 64'd0);

        pulse_reload();
        check("reload_err_clr", 64'(err), 64'd0);
`endif

        // Asynchronous reset in the middle of a load
        push(0, 0, 8'h11);
        push(0, 1, 8'h22);
        push(0, 2, 8'h33);
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h33, 1'b0, 0);
        stop_stream();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_s_ready", 64'(s_ready), 64'd0);
        check("arst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("arst_done", 64'(done), 64'd0);
        check("arst_m_en", 64'(m_en), 64'd0);
        check("arst_m_addr", 64'(m_addr), 64'd0);
        check("arst_m_wdata", 64'(m_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_idle", 64'(s_ready), 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
